button_debouncer: RTL and testbench
===================================

// Module: button_debouncer
//
// PURPOSE
//   Debounces one raw push-button input. Samples it on the slow square wave
//   produced by the clock divider (sampleClk), which is registered in the
//   clkIn domain. Outputs a clean level plus single-cycle press/release
//   pulses for downstream control logic. Sits directly downstream of the
//   divider and runs entirely on clkIn.
//
// PARAMETERS
//   STABLE_SAMPLES  4   consecutive equal samples needed to change state (>=2)
//   REPEAT_DELAY    8   strobes held before the first repeat pulse (repeat build only)
//   REPEAT_PERIOD   4   strobes between later repeat pulses (repeat build only)
//
// PORTS
//   clkIn         in   1  system clock; sole clock domain
//   rstN          in   1  synchronous, active-low reset
//   sampleClk     in   1  divided clock from divider; already synchronous to clkIn
//   btnIn         in   1  raw asynchronous button, active high
//   btnOut        out  1  debounced level
//   pressPulse    out  1  one-cycle pulse on debounced 0->1
//   releasePulse  out  1  one-cycle pulse on debounced 1->0
//   repeatPulse   out  1  one-cycle auto-repeat pulse while held (0 if not built)
//
// BEHAVIOUR
//   - Reset (rstN=0 at posedge clkIn): outputs 0, state RELEASED, counters 0,
//     sync flops 0, sampleQ 0. Reset wins over any simultaneous event.
//   - btnIn passes through a 2-flop synchroniser -> btnSync.
//   - strobe = sampleClk & ~sampleQ, where sampleQ is sampleClk delayed one
//     clkIn cycle. strobe is one cycle long per sampleClk rising edge.
//   - No strobe means no state or counter change; a stuck sampleClk freezes the FSM.
//   - cnt width is $clog2(STABLE_SAMPLES+1). On a given strobe:
//     RELEASED:     btnSync=1 -> PRESS_PEND, cnt=1; else stay.
//     PRESS_PEND:   btnSync=1 -> cnt+1; when cnt+1==STABLE_SAMPLES go to
//                   PRESSED, cnt=0. btnSync=0 -> RELEASED, cnt=0.
//     PRESSED:      btnSync=0 -> RELEASE_PEND, cnt=1; else stay.
//     RELEASE_PEND: btnSync=0 -> cnt+1; when cnt+1==STABLE_SAMPLES go to
//                   RELEASED, cnt=0. btnSync=1 -> PRESSED, cnt=0.
//   - All outputs are registered. btnOut = (state==PRESSED || RELEASE_PEND).
//   - pressPulse/releasePulse are high exactly in the cycle btnOut changes,
//     i.e. one clkIn cycle after the qualifying strobe. They are never both high.
//   - Reset mid-operation discards partial counts. A button still held after
//     reset needs a full STABLE_SAMPLES run and produces a fresh pressPulse.
//   - Elaboration error if STABLE_SAMPLES<2.
//
// CONFIGURATION
//   DEBOUNCE_REPEAT_EN defined:
//     - repCnt counts strobes while in PRESSED.
//     - repeatPulse fires (one cycle, registered) on strobe REPEAT_DELAY after
//       entry, then every REPEAT_PERIOD strobes.
//     - repCnt clears on entering PRESSED and on entering RELEASE_PEND. A
//       bounce back into PRESSED restarts the delay.
//     - repCnt saturates rather than wraps.
//   DEBOUNCE_REPEAT_EN undefined:
//     - repeatPulse is tied to 0; no repeat logic; REPEAT_* are ignored.
//
// TESTING  (STABLE_SAMPLES=4; sampleClk period 10 clkIn cycles)
//   1. Reset: rstN=0 for 2 cycles with btnIn=1 and sampleClk toggling ->
//      all outputs 0 throughout.
//   2. Clean press: btnIn=1 held -> btnOut=1 and pressPulse high one cycle,
//      one cycle after the 4th strobe that sees btnSync=1; exactly one pulse.
//   3. Bounce: btnSync high for 3 strobes, low for 1, high for 4 -> no pulse
//      before the final run; a single pressPulse after its 4th strobe.
//   4. Release: from PRESSED, btnIn=0 for 4 strobes -> btnOut=0 and
//      releasePulse high one cycle; a 1-strobe glitch high midway restarts
//      the count.
//   5. Reset mid PRESS_PEND after 3 high strobes, btnIn kept 1 -> no pulse
//      until 4 further strobes after reset release.
//   6. Macro defined, REPEAT_DELAY=8, REPEAT_PERIOD=4, hold 20 strobes past
//      press -> repeatPulse at strobes 8, 12, 16, 20. Macro undefined ->
//      repeatPulse never 1.

Source files
------------

// File: rtl/button_debouncer_if.sv
// ============================================================================
// Module      : button_debouncer_if
// Description : Sample strobe, raw button and debounced outputs of the
//               push-button debouncer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface button_debouncer_if;
   logic sampleClk;
   logic btnIn;
   logic btnOut;
   logic pressPulse;
   logic releasePulse;
   logic repeatPulse;

   modport master (
      output sampleClk,
      output btnIn,
      input  btnOut,
      input  pressPulse,
      input  releasePulse,
      input  repeatPulse
   );

   modport slave (
      input  sampleClk,
      input  btnIn,
      output btnOut,
      output pressPulse,
      output releasePulse,
      output repeatPulse
   );
endinterface

`default_nettype wire

// File: rtl/button_debouncer.sv
// ============================================================================
// Module      : button_debouncer
// Description : Debounces one raw push-button on strobes derived from the
//               divided sampleClk; registered level, press/release pulses and
//               optional auto-repeat (enabled by defining DEBOUNCE_REPEAT_EN).
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module button_debouncer #(
   parameter int STABLE_SAMPLES = 4,
   parameter int REPEAT_DELAY   = 8,
   parameter int REPEAT_PERIOD  = 4
) (
   input  wire logic          clkIn,
   input  wire logic          rstN,
   button_debouncer_if.slave  bus
);

   generate
      if (STABLE_SAMPLES < 2 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_badParams
         $error("button_debouncer: STABLE_SAMPLES must be >= 2 and REPEAT_* >= 1");
      end
   endgenerate

   localparam int                 c_CNT_W    = $clog2(STABLE_SAMPLES + 1);
   localparam logic [c_CNT_W-1:0] c_CNT_ZERO = '0;
   localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
   localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(STABLE_SAMPLES);

   typedef enum logic [1:0] {
      RELEASED     = 2'd0,
      PRESS_PEND   = 2'd1,
      PRESSED      = 2'd2,
      RELEASE_PEND = 2'd3
   } state_t;

   logic               r_sync1;
   logic               r_btnSync;
   logic               r_sampleQ;
   logic               w_strobe;
   state_t             r_state;
   state_t             w_nextState;
   logic [c_CNT_W-1:0] r_cnt;
   logic [c_CNT_W-1:0] w_nextCnt;
   logic [c_CNT_W-1:0] w_cntInc;
   logic               w_nextBtnOut;
   logic               r_btnOut;
   logic               r_pressPulse;
   logic               r_releasePulse;

   // Two-flop synchroniser for the raw button, plus the sampleClk edge detector
   always_ff @(posedge clkIn) begin
      if (!rstN) begin
         r_sync1   <= 1'b0;
         r_btnSync <= 1'b0;
         r_sampleQ <= 1'b0;
      end else begin
         r_sync1   <= bus.btnIn;
         r_btnSync <= r_sync1;
         r_sampleQ <= bus.sampleClk;
      end
   end

   assign w_strobe = bus.sampleClk & ~r_sampleQ;
   assign w_cntInc = r_cnt + c_CNT_ONE;

   always_ff @(posedge clkIn) begin
      if (!rstN) begin
         r_state <= RELEASED;
         r_cnt   <= c_CNT_ZERO;
      end else begin
         r_state <= w_nextState;
         r_cnt   <= w_nextCnt;
      end
   end

   always_comb begin
      w_nextState = r_state;
      w_nextCnt   = r_cnt;
      if (w_strobe) begin
         case (r_state)
            RELEASED: begin
               if (r_btnSync) begin
                  w_nextState = PRESS_PEND;
                  w_nextCnt   = c_CNT_ONE;
               end
            end
            PRESS_PEND: begin
               if (!r_btnSync) begin
                  w_nextState = RELEASED;
                  w_nextCnt   = c_CNT_ZERO;
               end else if (w_cntInc == c_CNT_LAST) begin
                  w_nextState = PRESSED;
                  w_nextCnt   = c_CNT_ZERO;
               end else begin
                  w_nextCnt   = w_cntInc;
               end
            end
            PRESSED: begin
               if (!r_btnSync) begin
                  w_nextState = RELEASE_PEND;
                  w_nextCnt   = c_CNT_ONE;
               end
            end
            RELEASE_PEND: begin
               if (r_btnSync) begin
                  w_nextState = PRESSED;
                  w_nextCnt   = c_CNT_ZERO;
               end else if (w_cntInc == c_CNT_LAST) begin
                  w_nextState = RELEASED;
                  w_nextCnt   = c_CNT_ZERO;
               end else begin
                  w_nextCnt   = w_cntInc;
               end
            end
            default: begin
               w_nextState = RELEASED;
               w_nextCnt   = c_CNT_ZERO;
            end
         endcase
      end
   end

   // The release-pending state still reports the button as held
   assign w_nextBtnOut = (w_nextState == PRESSED) || (w_nextState == RELEASE_PEND);

   always_ff @(posedge clkIn) begin
      if (!rstN) begin
         r_btnOut       <= 1'b0;
         r_pressPulse   <= 1'b0;
         r_releasePulse <= 1'b0;
      end else begin
         r_btnOut       <= w_nextBtnOut;
         r_pressPulse   <= w_nextBtnOut & ~r_btnOut;
         r_releasePulse <= ~w_nextBtnOut & r_btnOut;
      end
   end

   assign bus.btnOut       = r_btnOut;
   assign bus.pressPulse   = r_pressPulse;
   assign bus.releasePulse = r_releasePulse;

`ifdef DEBOUNCE_REPEAT_EN
   localparam int                 c_REP_MAX    = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
   localparam int                 c_REP_W      = $clog2(c_REP_MAX + 1);
   localparam logic [c_REP_W-1:0] c_REP_ZERO   = '0;
   localparam logic [c_REP_W-1:0] c_REP_ONE    = c_REP_W'(1);
   localparam logic [c_REP_W-1:0] c_REP_SAT    = '1;
   localparam logic [c_REP_W-1:0] c_REP_DELAY  = c_REP_W'(REPEAT_DELAY);
   localparam logic [c_REP_W-1:0] c_REP_PERIOD = c_REP_W'(REPEAT_PERIOD);

   logic [c_REP_W-1:0] r_repCnt;
   logic [c_REP_W-1:0] w_repInc;
   logic               r_repArmed;
   logic               r_repeatPulse;
   logic               w_repHold;
   logic               w_repFire;
   logic               w_repClear;

   // Only strobes that keep the FSM in PRESSED advance the repeat timer
   assign w_repHold  = w_strobe && (r_state == PRESSED) && r_btnSync;
   assign w_repInc   = (r_repCnt == c_REP_SAT) ? r_repCnt : (r_repCnt + c_REP_ONE);
   assign w_repFire  = w_repHold && (r_repArmed ? (w_repInc == c_REP_PERIOD)
                                                : (w_repInc == c_REP_DELAY));
   assign w_repClear = ((w_nextState == PRESSED)      && (r_state != PRESSED)) ||
                       ((w_nextState == RELEASE_PEND) && (r_state != RELEASE_PEND));

   always_ff @(posedge clkIn) begin
      if (!rstN) begin
         r_repCnt      <= c_REP_ZERO;
         r_repArmed    <= 1'b0;
         r_repeatPulse <= 1'b0;
      end else begin
         r_repeatPulse <= w_repFire;
         if (w_repClear) begin
            r_repCnt   <= c_REP_ZERO;
            r_repArmed <= 1'b0;
         end else if (w_repFire) begin
            r_repCnt   <= c_REP_ZERO;
            r_repArmed <= 1'b1;
         end else if (w_repHold) begin
            r_repCnt   <= w_repInc;
         end
      end
   end

   assign bus.repeatPulse = r_repeatPulse;
`else
   assign bus.repeatPulse = 1'b0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_button_debouncer.sv
// ============================================================================
// Module      : tb_button_debouncer
// Description : Scoreboard bench for button_debouncer (STABLE_SAMPLES=4,
//               sampleClk period 10 clkIn cycles); honours DEBOUNCE_REPEAT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_button_debouncer;

   localparam logic [2:0] c_NONE = 3'b000;
   localparam logic [2:0] c_PRS  = 3'b001;
   localparam logic [2:0] c_REL  = 3'b010;
   localparam logic [2:0] c_RPT  = 3'b100;

   typedef struct {
      logic [2:0] kind;
      int         cyc;
   } pulse_t;

   typedef struct {
      int   cyc;
      logic level;
      logic resetChk;
   } level_t;

   logic     clkIn = 1'b0;
   logic     rstN  = 1'b0;
   int       cyc   = 0;
   int       checks = 0;
   int       errors = 0;
   logic     done  = 1'b0;
   pulse_t   pq[$];
   level_t   lq[$];
   pulse_t   pe;
   level_t   le;
   logic [2:0] seen;

   button_debouncer_if bus ();

   button_debouncer #(
      .STABLE_SAMPLES (4),
      .REPEAT_DELAY   (8),
      .REPEAT_PERIOD  (4)
   ) dut (
      .clkIn (clkIn),
      .rstN  (rstN),
      .bus   (bus)
   );

   always #5 clkIn = ~clkIn;
   always @(posedge clkIn) cyc <= cyc + 1;

   // One sampleClk period with btnIn at lvl: the strobe lands after the
   // synchroniser has settled, so the FSM sees exactly one sample of lvl.
   task automatic tick(input logic lvl, input logic [2:0] expPulse, input logic expOut);
      for (int i = 0; i < 10; i++) begin
         @(posedge clkIn);
         #1;
         if (i == 0) bus.btnIn = lvl;
         bus.sampleClk = (i >= 5);
         if (i == 5 && expPulse != c_NONE) pq.push_back('{kind: expPulse, cyc: cyc + 1});
         if (i == 9) lq.push_back('{cyc: cyc, level: expOut, resetChk: 1'b0});
      end
   endtask

   task automatic holdTicks(input logic lvl, input int n, input logic expOut);
      for (int k = 0; k < n; k++) tick(lvl, c_NONE, expOut);
   endtask

   task automatic resetPhase(input int n);
      rstN = 1'b0;
      bus.btnIn = 1'b1;
      for (int i = 0; i < n; i++) begin
         @(posedge clkIn);
         #1;
         bus.sampleClk = ~bus.sampleClk;
         lq.push_back('{cyc: cyc, level: 1'b0, resetChk: 1'b1});
      end
      rstN = 1'b1;
      bus.sampleClk = 1'b0;
   endtask

   initial begin
      bus.sampleClk = 1'b0;
      bus.btnIn     = 1'b0;

      resetPhase(2);

      // Clean press with button held through reset
      holdTicks(1'b1, 3, 1'b0);
      tick(1'b1, c_PRS, 1'b1);
      tick(1'b1, c_NONE, 1'b1);

      // Release with a one-strobe glitch restarting the count
      tick(1'b0, c_NONE, 1'b1);
      tick(1'b0, c_NONE, 1'b1);
      tick(1'b1, c_NONE, 1'b1);
      holdTicks(1'b0, 3, 1'b1);
      tick(1'b0, c_REL, 1'b0);

      // Bounce: 3 high, 1 low, then 4 high
      holdTicks(1'b1, 3, 1'b0);
      tick(1'b0, c_NONE, 1'b0);
      holdTicks(1'b1, 3, 1'b0);
      tick(1'b1, c_PRS, 1'b1);

      holdTicks(1'b0, 3, 1'b1);
      tick(1'b0, c_REL, 1'b0);

      // Reset in PRESS_PEND discards the partial count
      holdTicks(1'b1, 3, 1'b0);
      resetPhase(2);
      holdTicks(1'b1, 3, 1'b0);
      tick(1'b1, c_PRS, 1'b1);

      // Long hold: auto-repeat at strobes 8, 12, 16, 20 after the press
      for (int k = 1; k <= 20; k++) begin
`ifdef DEBOUNCE_REPEAT_EN
         tick(1'b1, (k >= 8 && (k - 8) % 4 == 0) ? c_RPT : c_NONE, 1'b1);
`else
         tick(1'b1, c_NONE, 1'b1);
`endif
      end

      holdTicks(1'b0, 3, 1'b1);
      tick(1'b0, c_REL, 1'b0);

      repeat (3) @(posedge clkIn);
      #1;
      done = 1'b1;
   end

   always @(negedge clkIn) begin
      seen = {bus.repeatPulse, bus.releasePulse, bus.pressPulse};
      if (seen != c_NONE) begin
         checks++;
         if (pq.size() == 0) begin
            errors++;
            $display("FAIL pulse: got %b at cycle %0d, expected none", seen, cyc);
         end else begin
            pe = pq.pop_front();
            if (pe.kind !== seen || pe.cyc != cyc) begin
               errors++;
               $display("FAIL pulse: got %b at cycle %0d, expected %b at cycle %0d",
                        seen, cyc, pe.kind, pe.cyc);
            end
         end
      end
      if (lq.size() != 0 && lq[0].cyc <= cyc) begin
         le = lq.pop_front();
         checks++;
         if (le.resetChk) begin
            if ({seen, bus.btnOut} !== 4'b0000) begin
               errors++;
               $display("FAIL reset outputs: got %b at cycle %0d, expected 0000",
                        {seen, bus.btnOut}, cyc);
            end
         end else if (bus.btnOut !== le.level) begin
            errors++;
            $display("FAIL btnOut level: got %b at cycle %0d, expected %b",
                     bus.btnOut, cyc, le.level);
         end
      end
      if (done) begin
         while (pq.size() != 0) begin
            pe = pq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing pulse: got none, expected %b at cycle %0d", pe.kind, pe.cyc);
         end
         $display("Result: errors=%0d of %0d checks", errors, checks);
         $finish;
      end
   end

endmodule

`default_nettype wire
